intr_ctrl: RTL and testbench
============================

INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 11, meaning number of interrupt source lines (1..32).
REQ-002 SHALL have port clk  input  1  meaning the single clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  meaning reset, synchronous and active-high.
REQ-004 SHALL have port hw_addr  input  32  meaning full CPU byte address of the HW-register access.
REQ-005 SHALL have port hw_data_i  input  32  meaning write data from the initiator.
REQ-006 SHALL have port hw_wen  input  1  meaning write strobe, level, held by the initiator until ack.
REQ-007 SHALL have port hw_ren  input  1  meaning read strobe, level, held by the initiator until ack.
REQ-008 SHALL have port hw_data_o  output  32  meaning read data, registered.
REQ-009 SHALL have port hw_ack  output  1  meaning one-cycle completion pulse, registered.
REQ-010 SHALL have port irq_src  input  NUM_IRQ  meaning raw interrupt requests, synchronous to clk.
REQ-011 SHALL have port cpu_irq  output  1  meaning interrupt request to the CPU, registered.

Function
REQ-012 SHALL decode on hw_addr[28:0] so that KUSEG/KSEG0/KSEG1 mirrors alias: 0x1F801070 = I_STAT, 0x1F801074 = I_MASK.
REQ-013 SHALL treat any other address as unmapped: read returns 0, write is discarded, ack still issued.
REQ-014 SHALL implement FSM states IDLE, ACK, HOLD.
REQ-015 IDLE: on a cycle with hw_ren or hw_wen high, SHALL go to ACK; hw_ren has priority if both are high (read only, no write).
REQ-016 At the IDLE->ACK edge SHALL commit the write (if any) and load hw_data_o with the read value (if read); hw_ack = 1 in the following cycle.
REQ-017 ACK: hw_ack high for exactly one cycle; SHALL go to HOLD unconditionally.
REQ-018 HOLD: SHALL stay until hw_ren and hw_wen are both low, then go to IDLE; no second ack and no second write while a strobe is still held.
REQ-019 hw_data_o SHALL hold its value until the next read commits; writes never alter it.
REQ-020 Read value: I_STAT -> {zeros, stat[NUM_IRQ-1:0]}; I_MASK -> {zeros, mask[NUM_IRQ-1:0]}.
REQ-021 Edge detect: a bit of stat SHALL set on a 0->1 transition of irq_src (prev-sample register); level-high alone does not re-set.
REQ-022 I_STAT write: stat <= (stat & hw_data_i[NUM_IRQ-1:0]) | new_edges (write 0 acknowledges, write 1 keeps).
REQ-023 Simultaneous edge and I_STAT clear on the same bit: set SHALL win.
REQ-024 I_MASK write: mask <= hw_data_i[NUM_IRQ-1:0]; upper bits ignored.
REQ-025 cpu_irq SHALL be registered |(stat & mask), i.e. one cycle after stat/mask update.
REQ-026 Latency: strobe first seen in cycle T -> hw_ack in T+1; data valid from T+1 until the next read.

Reset
REQ-027 On rst: state = IDLE, hw_ack = 0, hw_data_o = 0, stat = 0, mask = 0, irq_prev = 0, cpu_irq = 0.
REQ-028 rst mid-transaction SHALL abort with no ack; the pending write is lost; a strobe still high after reset SHALL start a fresh transaction.
REQ-029 irq_prev cleared by reset: an irq_src already high at reset release SHALL register one edge.

Structure
REQ-030 Address constants (I_STAT_ADDR, I_MASK_ADDR, decode mask) and the FSM state enum SHALL live in package psx_hwreg_pkg for reuse by later HW-register responders.
REQ-031 Edge detection SHALL be a sub-module irq_edge_detect (NUM_IRQ wide, clk/rst, outputs per-bit rising-edge pulse).

Verification
REQ-032 Read I_MASK at 0x1F801074 after reset -> hw_ack one cycle later, hw_data_o = 0, single ack despite hw_ren held 3 cycles.
REQ-033 Write 0x0000_0005 to I_MASK via 0xBF801074 (hold hw_wen 2 cycles) -> mask = 0x005, one ack, readback via 0x9F801074 = 0x5.
REQ-034 Pulse irq_src[0] 0->1 with mask = 0x001 -> stat bit0 = 1 next cycle, cpu_irq = 1 one cycle after that; write I_STAT 0x7FE -> stat = 0, cpu_irq falls.
REQ-035 Rising edge on irq_src[2] in the same cycle as I_STAT write 0x000 commits -> stat = 0x004.
REQ-036 Read 0x1F801100 (unmapped) -> hw_ack after 1 cycle, hw_data_o = 0; write there -> ack, stat/mask unchanged.
REQ-037 Assert rst in ACK cycle of a write -> hw_ack low next cycle, mask = 0, FSM IDLE; hw_ren then asserted -> normal ack.

Source files
------------

// File: rtl/psx_hwreg_pkg.sv
// ---------------------------------------------------------------------------
// psx_hwreg_pkg
// Shared definitions for PSX-style HW-register responders.
// Contents:
//   - register byte addresses for the interrupt controller (I_STAT, I_MASK)
//   - address decode mask that folds the KUSEG/KSEG0/KSEG1 mirrors together
//   - bus-handshake FSM state enum (IDLE -> ACK -> HOLD)
//   - addr_hit(): mirror-aware register address comparison
// ---------------------------------------------------------------------------
package psx_hwreg_pkg;

  // Register addresses as seen in KUSEG; the mirrors differ only in [31:29].
  localparam logic [31:0] I_STAT_ADDR       = 32'h1F80_1070;
  localparam logic [31:0] I_MASK_ADDR       = 32'h1F80_1074;

  // Keeps hw_addr[28:0]; dropping [31:29] makes 0x1F.., 0x9F.. and 0xBF.. alias.
  localparam logic [31:0] HWREG_DECODE_MASK = 32'h1FFF_FFFF;

  // Handshake states shared by every HW-register responder.
  typedef enum logic [1:0] {
    IDLE = 2'd0,  // waiting for a read or write strobe
    ACK  = 2'd1,  // access committed, hw_ack high for this single cycle
    HOLD = 2'd2   // waiting for the initiator to drop its strobes
  } hwreg_state_t;

  // True when a CPU address hits a register in any of the segment mirrors.
  function automatic logic addr_hit(input logic [31:0] addr,
                                    input logic [31:0] reg_addr);
    return (addr & HWREG_DECODE_MASK) == (reg_addr & HWREG_DECODE_MASK);
  endfunction

endpackage

// File: rtl/irq_edge_detect.sv
// ---------------------------------------------------------------------------
// irq_edge_detect
// Per-bit rising-edge detector for synchronous interrupt request lines.
// A bit of edges is high for the one cycle in which irq_src is 1 and the
// previous sample was 0. A level held high produces no further pulses.
// Because the previous-sample register clears on reset, a line that is
// already high when reset is released yields exactly one edge.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset
//   irq_src  in   [WIDTH] raw interrupt request lines
//   edges    out  [WIDTH] rising-edge pulses (combinational from irq_src)
// ---------------------------------------------------------------------------
module irq_edge_detect #(
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] irq_src,
  output logic [WIDTH-1:0] edges
);

  logic [WIDTH-1:0] irq_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_prev <= '0;
    end else begin
      irq_prev <= irq_src;
    end
  end

  assign edges = irq_src & ~irq_prev;

endmodule

// File: rtl/intr_ctrl.sv
// ---------------------------------------------------------------------------
// intr_ctrl
// PSX-style interrupt controller with two HW registers:
//   I_STAT (0x1F801070): sticky rising-edge status; write 0 acknowledges a
//                        bit, write 1 keeps it; a new edge always wins.
//   I_MASK (0x1F801074): interrupt enable mask.
// cpu_irq is the registered OR of (stat & mask).
// Bus handshake: a level strobe seen in IDLE commits the access and gives
// one hw_ack pulse in the following cycle; the FSM then waits in HOLD until
// both strobes are low, so a held strobe never produces a second access.
// Read has priority when both strobes are high. Unmapped addresses read 0,
// discard writes and still acknowledge.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   hw_addr    in   [32] CPU byte address (decoded on [28:0])
//   hw_data_i  in   [32] write data
//   hw_wen     in   write strobe, level, held until ack
//   hw_ren     in   read strobe, level, held until ack
//   hw_data_o  out  [32] registered read data, held until the next read
//   hw_ack     out  registered one-cycle completion pulse
//   irq_src    in   [NUM_IRQ] raw interrupt requests, synchronous to clk
//   cpu_irq    out  registered interrupt request to the CPU
// ---------------------------------------------------------------------------
module intr_ctrl
  import psx_hwreg_pkg::*;
#(
  parameter int NUM_IRQ = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        hw_addr,
  input  logic [31:0]        hw_data_i,
  input  logic               hw_wen,
  input  logic               hw_ren,
  output logic [31:0]        hw_data_o,
  output logic               hw_ack,
  input  logic [NUM_IRQ-1:0] irq_src,
  output logic               cpu_irq
);

  hwreg_state_t       state;
  logic [NUM_IRQ-1:0] stat;
  logic [NUM_IRQ-1:0] mask;
  logic [NUM_IRQ-1:0] new_edges;
  logic [NUM_IRQ-1:0] stat_next;
  logic [NUM_IRQ-1:0] mask_next;
  logic [31:0]        read_val;
  logic               hit_stat;
  logic               hit_mask;
  logic               start;
  logic               rd_commit;
  logic               wr_commit;

  irq_edge_detect #(
    .WIDTH (NUM_IRQ)
  ) u_edge_detect (
    .clk     (clk),
    .rst     (rst),
    .irq_src (irq_src),
    .edges   (new_edges)
  );

  // Bits of the write data above the implemented sources are ignored.
  if (NUM_IRQ < 32) begin : g_unused_data
    logic unused_data;
    assign unused_data = ^hw_data_i[31:NUM_IRQ];
  end

  // Access decode and next register values.
  // NOTE: every always_comb output gets a default before any branch; a path
  // that leaves a signal unassigned would infer a latch.
  always_comb begin
    hit_stat  = addr_hit(hw_addr, I_STAT_ADDR);
    hit_mask  = addr_hit(hw_addr, I_MASK_ADDR);

    start     = (state == IDLE) && (hw_ren || hw_wen);
    rd_commit = start && hw_ren;
    wr_commit = start && !hw_ren && hw_wen;

    read_val = '0;
    if (hit_stat) begin
      read_val[NUM_IRQ-1:0] = stat;
    end else if (hit_mask) begin
      read_val[NUM_IRQ-1:0] = mask;
    end

    // Acknowledge first, then OR in fresh edges so a simultaneous edge on a
    // bit being cleared leaves that bit set.
    stat_next = stat;
    if (wr_commit && hit_stat) begin
      stat_next = stat & hw_data_i[NUM_IRQ-1:0];
    end
    stat_next = stat_next | new_edges;

    mask_next = mask;
    if (wr_commit && hit_mask) begin
      mask_next = hw_data_i[NUM_IRQ-1:0];
    end
  end

  // Handshake FSM with registered outputs, plus the register file.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      hw_ack    <= 1'b0;
      hw_data_o <= '0;
      stat      <= '0;
      mask      <= '0;
      cpu_irq   <= 1'b0;
    end else begin
      stat    <= stat_next;
      mask    <= mask_next;
      // Built from the current registers, so it trails a stat/mask update by one cycle.
      cpu_irq <= |(stat & mask);
      hw_ack  <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            state  <= ACK;
            hw_ack <= 1'b1;
          end
          if (rd_commit) begin
            hw_data_o <= read_val;
          end
        end
        ACK: begin
          state <= HOLD;
        end
        HOLD: begin
          if (!hw_ren && !hw_wen) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_intr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_intr_ctrl
// Directed bench for intr_ctrl. Expected values are pushed to a scoreboard
// queue when stimulus is driven and popped as the DUT responds. Inputs are
// driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_intr_ctrl;
  import psx_hwreg_pkg::*;

  localparam int NUM_IRQ = 11;

  logic               clk = 1'b0;
  logic               rst;
  logic [31:0]        hw_addr;
  logic [31:0]        hw_data_i;
  logic               hw_wen;
  logic               hw_ren;
  logic [31:0]        hw_data_o;
  logic               hw_ack;
  logic [NUM_IRQ-1:0] irq_src;
  logic               cpu_irq;

  typedef struct {
    string       tag;
    logic [31:0] value;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  intr_ctrl #(
    .NUM_IRQ (NUM_IRQ)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .hw_addr   (hw_addr),
    .hw_data_i (hw_data_i),
    .hw_wen    (hw_wen),
    .hw_ren    (hw_ren),
    .hw_data_o (hw_data_o),
    .hw_ack    (hw_ack),
    .irq_src   (irq_src),
    .cpu_irq   (cpu_irq)
  );

  task automatic push_exp(input string tag, input logic [31:0] value);
    exp_t e;
    e.tag   = tag;
    e.value = value;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] observed);
    exp_t e;
    n_assert++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed=0x%0h expected=<none queued>", observed);
    end else begin
      e = sb.pop_front();
      assert (observed === e.value) else begin
        n_fail++;
        $error("FAIL %s: observed=0x%0h expected=0x%0h", e.tag, observed, e.value);
      end
    end
  endtask

  // One bus access: strobes driven for 'hold' cycles, then dropped. Counts
  // acks and records the cycle of the first one within a bounded window.
  task automatic bus(input logic ren, input logic wen, input logic [31:0] addr,
                     input logic [31:0] wdata, input int hold,
                     input logic [NUM_IRQ-1:0] src);
    int acks;
    int first;
    acks  = 0;
    first = -1;
    @(negedge clk);
    hw_addr   = addr;
    hw_data_i = wdata;
    hw_ren    = ren;
    hw_wen    = wen;
    irq_src   = src;
    for (int c = 1; c <= hold + 3; c++) begin
      @(negedge clk);
      if (hw_ack) begin
        acks++;
        if (first < 0) first = c;
      end
      if (c == hold) begin
        hw_ren = 1'b0;
        hw_wen = 1'b0;
      end
    end
    pop_check(32'(acks));
    pop_check(32'(first));
  endtask

  task automatic rd(input string tag, input logic [31:0] addr, input int hold,
                    input logic [31:0] exp_data);
    push_exp({tag, "_acks"}, 32'd1);
    push_exp({tag, "_lat"},  32'd1);
    push_exp({tag, "_data"}, exp_data);
    bus(1'b1, 1'b0, addr, 32'h0, hold, irq_src);
    pop_check(hw_data_o);
  endtask

  task automatic wr(input string tag, input logic [31:0] addr, input logic [31:0] data,
                    input int hold, input logic [NUM_IRQ-1:0] src);
    push_exp({tag, "_acks"}, 32'd1);
    push_exp({tag, "_lat"},  32'd1);
    bus(1'b0, 1'b1, addr, data, hold, src);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    hw_addr   = '0;
    hw_data_i = '0;
    hw_wen    = 1'b0;
    hw_ren    = 1'b0;
    irq_src   = '0;
    repeat (3) @(negedge clk);

    // Reset state
    push_exp("rst_ack", 32'd0);  pop_check(32'(hw_ack));
    push_exp("rst_data", 32'd0); pop_check(hw_data_o);
    push_exp("rst_irq", 32'd0);  pop_check(32'(cpu_irq));
    rst = 1'b0;

    // Read I_MASK after reset, strobe held 3 cycles -> single ack, data 0
    rd("mask_rd_rst", 32'h1F80_1074, 3, 32'h0);

    // Write 5 via KSEG1 mirror held 2 cycles; readback via KSEG0 mirror
    wr("mask_wr5", 32'hBF80_1074, 32'h0000_0005, 2, irq_src);
    push_exp("data_after_wr", 32'h0); pop_check(hw_data_o);
    rd("mask_rd5", 32'h9F80_1074, 1, 32'h5);

    // Upper write bits ignored
    wr("mask_wr1", 32'h1F80_1074, 32'hFFFF_F801, 1, irq_src);
    rd("mask_rd1", 32'h1F80_1074, 1, 32'h1);

    // Edge on irq_src[0] with mask=1: stat next cycle, cpu_irq one later
    irq_src = 11'h001;
    @(negedge clk);
    push_exp("stat_edge0", 32'h1); pop_check(32'(dut.stat));
    push_exp("irq_lag", 32'd0);    pop_check(32'(cpu_irq));
    @(negedge clk);
    push_exp("irq_rise", 32'd1);   pop_check(32'(cpu_irq));

    // Acknowledge via I_STAT write 0x7FE; level-high src must not re-set
    wr("stat_clr", 32'hBF80_1070, 32'h0000_07FE, 1, 11'h001);
    push_exp("irq_fall", 32'd0);   pop_check(32'(cpu_irq));
    rd("stat_rd0", 32'h1F80_1070, 1, 32'h0);

    // Edge on bit1, then clear-all while bit2 rises on the commit cycle
    irq_src = 11'h003;
    @(negedge clk);
    push_exp("stat_edge1", 32'h2); pop_check(32'(dut.stat));
    wr("stat_clr_race", 32'h1F80_1070, 32'h0, 1, 11'h005);
    rd("stat_rd_race", 32'h1F80_1070, 1, 32'h4);
    push_exp("irq_masked", 32'd0); pop_check(32'(cpu_irq));

    // Unmapped address: read 0, write discarded, both acknowledged
    rd("unmap_rd", 32'h1F80_1100, 1, 32'h0);
    wr("unmap_wr", 32'h1F80_1100, 32'hFFFF_FFFF, 1, irq_src);
    rd("unmap_stat", 32'h1F80_1070, 1, 32'h4);
    rd("unmap_mask", 32'h1F80_1074, 1, 32'h1);

    // Reset during the ACK cycle of a write
    @(negedge clk);
    hw_addr   = I_MASK_ADDR;
    hw_data_i = 32'h0000_03FF;
    hw_wen    = 1'b1;
    @(negedge clk);
    push_exp("ack_before_rst", 32'd1); pop_check(32'(hw_ack));
    rst = 1'b1;
    @(negedge clk);
    push_exp("ack_aborted", 32'd0);    pop_check(32'(hw_ack));
    push_exp("state_idle", 32'(IDLE)); pop_check(32'(dut.state));
    push_exp("mask_cleared", 32'h0);   pop_check(32'(dut.mask));
    rst    = 1'b0;
    hw_wen = 1'b0;

    // Lines high at reset release register one edge each (bits 0 and 2)
    rd("post_rst_mask", 32'h1F80_1074, 1, 32'h0);
    rd("post_rst_stat", 32'h1F80_1070, 1, 32'h5);

    // Both strobes high: read wins, write suppressed
    push_exp("both_acks", 32'd1);
    push_exp("both_lat", 32'd1);
    bus(1'b1, 1'b1, 32'h1F80_1074, 32'h0000_07FF, 1, irq_src);
    push_exp("both_data", 32'h0); pop_check(hw_data_o);
    rd("both_mask", 32'h1F80_1074, 1, 32'h0);

    // Enable bit2 -> cpu_irq asserts from pending stat
    wr("mask_wr4", 32'h1F80_1074, 32'h4, 1, irq_src);
    push_exp("irq_mask4", 32'd1); pop_check(32'(cpu_irq));

    push_exp("sb_drained", 32'd0); pop_check(32'(sb.size() - 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
